// File: rtl/msrv32_wb_port_arbiter.sv
// Writeback port arbiter: merges the pipeline writeback with a 2-entry buffer of
// multi-cycle results into the single integer register-file write port.
module msrv32_wb_port_arbiter (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        flush_in,
    input  logic        pipe_wr_en_in,
    input  logic [4:0]  pipe_rd_addr_in,
    input  logic [31:0] pipe_rd_data_in,
    input  logic        mc_valid_in,
    input  logic [4:0]  mc_rd_addr_in,
    input  logic [31:0] mc_rd_data_in,
    output logic        mc_ready_out,
    output logic        stall_out,
    output logic        wr_en_integer_file_out,
    output logic [4:0]  rf_rd_addr_out,
    output logic [31:0] rf_rd_data_out,
    output logic [1:0]  pending_count_out
);

    logic [4:0]  fifo_addr [2];
    logic [31:0] fifo_data [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic [1:0]  starve;

    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic        pipe_sel;
    logic        sel_valid;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;
    logic [1:0]  count_next;

    always_comb begin
        empty        = (count == 2'd0);
        full         = (count == 2'd2);
        mc_ready_out = !full;
        stall_out    = (starve == 2'd3) && !empty;
        push         = mc_valid_in && mc_ready_out;
        // A starved FIFO head outranks the pipeline; otherwise the pipeline wins.
        pipe_sel     = !stall_out && pipe_wr_en_in && !flush_in;
        pop          = !pipe_sel && !empty;
        sel_valid    = pipe_sel || pop;
        sel_addr     = pipe_sel ? pipe_rd_addr_in : fifo_addr[rd_ptr];
        sel_data     = pipe_sel ? pipe_rd_data_in : fifo_data[rd_ptr];
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (push) begin
            fifo_addr[wr_ptr] <= mc_rd_addr_in;
            fifo_data[wr_ptr] <= mc_rd_data_in;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            wr_ptr                 <= 1'b0;
            rd_ptr                 <= 1'b0;
            count                  <= 2'd0;
            starve                 <= 2'd0;
            wr_en_integer_file_out <= 1'b0;
            rf_rd_addr_out         <= 5'd0;
            rf_rd_data_out         <= 32'd0;
        end else begin
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count_next;

            if (pop || empty)
                starve <= 2'd0;
            else if (starve != 2'd3)
                starve <= starve + 2'd1;

            // x0 writes still consume the slot but never reach the register file.
            if (sel_valid) begin
                wr_en_integer_file_out <= (sel_addr != 5'd0);
                rf_rd_addr_out         <= sel_addr;
                rf_rd_data_out         <= sel_data;
            end else begin
                wr_en_integer_file_out <= 1'b0;
            end
        end
    end

    assign pending_count_out = count;

endmodule

// File: tb/tb_msrv32_wb_port_arbiter.sv
// Directed self-checking bench for msrv32_wb_port_arbiter with hand-computed expectations.
module tb_msrv32_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        flush_in;
    logic        pipe_wr_en_in;
    logic [4:0]  pipe_rd_addr_in;
    logic [31:0] pipe_rd_data_in;
    logic        mc_valid_in;
    logic [4:0]  mc_rd_addr_in;
    logic [31:0] mc_rd_data_in;
    logic        mc_ready_out;
    logic        stall_out;
    logic        wr_en_integer_file_out;
    logic [4:0]  rf_rd_addr_out;
    logic [31:0] rf_rd_data_out;
    logic [1:0]  pending_count_out;

    int checks;
    int failures;

    msrv32_wb_port_arbiter dut (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_in   (rst),
        .flush_in               (flush_in),
        .pipe_wr_en_in          (pipe_wr_en_in),
        .pipe_rd_addr_in        (pipe_rd_addr_in),
        .pipe_rd_data_in        (pipe_rd_data_in),
        .mc_valid_in            (mc_valid_in),
        .mc_rd_addr_in          (mc_rd_addr_in),
        .mc_rd_data_in          (mc_rd_data_in),
        .mc_ready_out           (mc_ready_out),
        .stall_out              (stall_out),
        .wr_en_integer_file_out (wr_en_integer_file_out),
        .rf_rd_addr_out         (rf_rd_addr_out),
        .rf_rd_data_out         (rf_rd_data_out),
        .pending_count_out      (pending_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle's inputs, then lets combinational outputs settle.
    task automatic applyStimulus(input logic flush, input logic pwe, input logic [4:0] pa,
                                 input logic [31:0] pd, input logic mv, input logic [4:0] ma,
                                 input logic [31:0] md);
        flush_in        = flush;
        pipe_wr_en_in   = pwe;
        pipe_rd_addr_in = pa;
        pipe_rd_data_in = pd;
        mc_valid_in     = mv;
        mc_rd_addr_in   = ma;
        mc_rd_data_in   = md;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkWrite(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
        checkOutput({tag, "_en"}, {31'd0, wr_en_integer_file_out}, {31'd0, en});
        checkOutput({tag, "_addr"}, {27'd0, rf_rd_addr_out}, {27'd0, a});
        checkOutput({tag, "_data"}, rf_rd_data_out, d);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("rst_ready", {31'd0, mc_ready_out}, 32'd1);
        checkOutput("rst_stall", {31'd0, stall_out}, 32'd0);
        tick();
        checkWrite("rst", 1'b0, 5'd0, 32'd0);
        checkOutput("rst_pending", {30'd0, pending_count_out}, 32'd0);
        rst = 1'b0;

        $display("[TB] pipeline-only write");
        applyStimulus(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        tick();
        checkWrite("pipe", 1'b1, 5'd5, 32'hDEADBEEF);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        checkWrite("idle_hold", 1'b0, 5'd5, 32'hDEADBEEF);

        $display("[TB] multi-cycle-only write");
        applyStimulus(0, 0, 0, 0, 1, 5'd7, 32'h1234);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("mc_pend_n1", {30'd0, pending_count_out}, 32'd1);
        checkOutput("mc_en_n1", {31'd0, wr_en_integer_file_out}, 32'd0);
        tick();
        checkWrite("mc", 1'b1, 5'd7, 32'h1234);
        checkOutput("mc_pend_n2", {30'd0, pending_count_out}, 32'd0);

        $display("[TB] contention and starvation stall");
        applyStimulus(0, 1, 5'd10, 32'h100, 1, 5'd3, 32'h33);
        tick();
        applyStimulus(0, 1, 5'd11, 32'h101, 0, 0, 0);
        checkOutput("cont_stall_n1", {31'd0, stall_out}, 32'd0);
        checkWrite("cont_n1", 1'b1, 5'd10, 32'h100);
        tick();
        applyStimulus(0, 1, 5'd12, 32'h102, 0, 0, 0);
        tick();
        applyStimulus(0, 1, 5'd13, 32'h103, 0, 0, 0);
        checkOutput("cont_stall_n3", {31'd0, stall_out}, 32'd0);
        tick();
        applyStimulus(0, 1, 5'd14, 32'h104, 0, 0, 0);
        checkOutput("cont_stall_n4", {31'd0, stall_out}, 32'd1);
        checkWrite("cont_n4", 1'b1, 5'd13, 32'h103);
        tick();
        checkWrite("cont_n5", 1'b1, 5'd3, 32'h33);
        applyStimulus(0, 1, 5'd14, 32'h104, 0, 0, 0);
        checkOutput("cont_stall_n5", {31'd0, stall_out}, 32'd0);
        tick();
        checkWrite("cont_n6", 1'b1, 5'd14, 32'h104);

        $display("[TB] full buffer");
        applyStimulus(0, 1, 5'd20, 32'h200, 1, 5'd1, 32'hA1);
        tick();
        applyStimulus(0, 1, 5'd21, 32'h201, 1, 5'd2, 32'hA2);
        checkOutput("full_ready_b", {31'd0, mc_ready_out}, 32'd1);
        checkOutput("full_pend_b", {30'd0, pending_count_out}, 32'd1);
        tick();
        applyStimulus(0, 1, 5'd22, 32'h202, 1, 5'd9, 32'hA9);
        checkOutput("full_ready_c", {31'd0, mc_ready_out}, 32'd0);
        checkOutput("full_pend_c", {30'd0, pending_count_out}, 32'd2);
        tick();
        applyStimulus(0, 1, 5'd23, 32'h203, 1, 5'd9, 32'hA9);
        checkOutput("full_pend_d", {30'd0, pending_count_out}, 32'd2);
        tick();
        applyStimulus(0, 1, 5'd24, 32'h204, 1, 5'd9, 32'hA9);
        checkOutput("full_stall_e", {31'd0, stall_out}, 32'd1);
        checkOutput("full_pend_e", {30'd0, pending_count_out}, 32'd2);
        tick();
        checkWrite("full_f", 1'b1, 5'd1, 32'hA1);
        applyStimulus(0, 1, 5'd24, 32'h204, 1, 5'd9, 32'hA9);
        checkOutput("full_pend_f", {30'd0, pending_count_out}, 32'd1);
        checkOutput("full_ready_f", {31'd0, mc_ready_out}, 32'd1);
        tick();
        checkWrite("full_g", 1'b1, 5'd24, 32'h204);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("full_pend_g", {30'd0, pending_count_out}, 32'd2);
        tick();
        checkWrite("full_h", 1'b1, 5'd2, 32'hA2);
        tick();
        checkWrite("full_i", 1'b1, 5'd9, 32'hA9);
        checkOutput("full_pend_i", {30'd0, pending_count_out}, 32'd0);
        tick();
        checkOutput("full_no_dup", {31'd0, wr_en_integer_file_out}, 32'd0);

        $display("[TB] flush and x0 writes");
        applyStimulus(1, 1, 5'd6, 32'h66, 0, 0, 0);
        tick();
        checkWrite("flush", 1'b0, 5'd9, 32'hA9);
        applyStimulus(0, 0, 0, 0, 1, 5'd0, 32'h55);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("x0_pend", {30'd0, pending_count_out}, 32'd1);
        tick();
        checkOutput("x0_en", {31'd0, wr_en_integer_file_out}, 32'd0);
        checkOutput("x0_pend_after", {30'd0, pending_count_out}, 32'd0);
        applyStimulus(0, 0, 0, 0, 1, 5'd8, 32'h88);
        tick();
        applyStimulus(1, 1, 5'd6, 32'h66, 0, 0, 0);
        tick();
        checkWrite("flush_fifo", 1'b1, 5'd8, 32'h88);

        $display("[TB] reset with entries pending");
        applyStimulus(0, 1, 5'd25, 32'h250, 1, 5'd1, 32'hB1);
        tick();
        applyStimulus(0, 1, 5'd26, 32'h260, 1, 5'd2, 32'hB2);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst2_pend_before", {30'd0, pending_count_out}, 32'd2);
        rst = 1'b1;
        tick();
        checkOutput("rst2_pend", {30'd0, pending_count_out}, 32'd0);
        checkOutput("rst2_ready", {31'd0, mc_ready_out}, 32'd1);
        checkOutput("rst2_stall", {31'd0, stall_out}, 32'd0);
        rst = 1'b0;
        tick();
        checkWrite("rst2_after", 1'b0, 5'd0, 32'd0);
        checkOutput("rst2_pend_after", {30'd0, pending_count_out}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
